// File: rtl/parking_pkg.sv
// parking_pkg: shared definitions for the parking entry controller.
//   state_e            - entry FSM states (IDLE, GRANT, BUSY)
//   DOOR_BLINK_CYC     - door blink length in clk_2Hz cycles
//   DOOR_BUSY_CYC_DEF  - default grant lockout (latch + blink + clear)
//   DEBOUNCE_CYC_DEF   - default synchronised-high samples to qualify a sensor
//   DENY_BLINK_CYC     - deny_led toggle length after a full-lot denial
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_e;

    localparam int unsigned DOOR_BLINK_CYC    = 20;
    localparam int unsigned DOOR_BUSY_CYC_DEF = DOOR_BLINK_CYC + 2;
    localparam int unsigned DEBOUNCE_CYC_DEF  = 2;
    localparam int unsigned DENY_BLINK_CYC    = 4;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser, saturating debounce counter and
// one-shot event generator for one raw sensor level.
//   clk_2Hz  in  system tick
//   reset    in  asynchronous, active-low
//   sensor_i in  raw sensor level
//   event_o  out one-cycle pulse when the synced level has been high for
//                DEBOUNCE_CYC consecutive samples; re-arms only after low
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk_2Hz,
    input  logic reset,
    input  logic sensor_i,
    output logic event_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          event_q, event_d;

    // Saturating at DEBOUNCE_CYC gives the one-event-per-assertion re-arm:
    // the count can only pass DEBOUNCE_CYC-1 again after clearing on low.
    always_comb begin
        cnt_d   = cnt_q;
        event_d = 1'b0;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEBOUNCE_CYC)) begin
            cnt_d   = cnt_q + 1'b1;
            event_d = (cnt_q == CW'(DEBOUNCE_CYC - 1));
        end
    end

    always_ff @(posedge clk_2Hz or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            event_q <= event_d;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/parking_entry_ctrl.sv
// parking_entry_ctrl: entry-side gate controller. Debounces arrival/exit
// sensors, tracks occupancy against CAPACITY, issues a one-cycle open_signal
// grant and locks out further grants for DOOR_BUSY_CYC cycles.
//   clk_2Hz     in   2 Hz system clock
//   reset       in   asynchronous, active-low
//   car_arrive  in   raw entry sensor level
//   car_exit    in   raw exit sensor level
//   open_signal out  one-cycle grant pulse to the door stage
//   free_spaces out  CAPACITY minus occupancy
//   full        out  occupancy == CAPACITY
//   busy        out  high during grant and lockout
//   deny_led    out  full-lot denial blink
// Build option: define PARKING_DENY_LED_EN to enable the deny_led blink;
// otherwise deny_led is tied low.
module parking_entry_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY      = 8,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int unsigned DOOR_BUSY_CYC = DOOR_BUSY_CYC_DEF
) (
    input  logic             clk_2Hz,
    input  logic             reset,
    input  logic             car_arrive,
    input  logic             car_exit,
    output logic             open_signal,
    output logic [CNT_W-1:0] free_spaces,
    output logic             full,
    output logic             busy,
    output logic             deny_led
);

    localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
    localparam int unsigned      BW        = $clog2(DOOR_BUSY_CYC);
    localparam logic [BW-1:0]    BUSY_LAST = BW'(DOOR_BUSY_CYC - 2);

    logic             arrive_evt, exit_evt;
    state_e           state_q;
    logic             pending_q, open_q, busy_q;
    logic [CNT_W-1:0] occ_q;
    logic [BW-1:0]    busy_cnt_q;
    logic             full_w, service, grant, exit_ok;

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arrive (
        .clk_2Hz (clk_2Hz),
        .reset   (reset),
        .sensor_i(car_arrive),
        .event_o (arrive_evt)
    );

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_exit (
        .clk_2Hz (clk_2Hz),
        .reset   (reset),
        .sensor_i(car_exit),
        .event_o (exit_evt)
    );

    // A same-cycle arrival event counts as pending so the grant lands one
    // edge after the event rather than two.
    assign full_w  = (occ_q == CAP_V);
    assign service = (state_q == IDLE) && (pending_q || arrive_evt);
    assign grant   = service && !full_w;
    assign exit_ok = exit_evt && (occ_q != '0);

    always_ff @(posedge clk_2Hz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            open_q     <= 1'b0;
            busy_q     <= 1'b0;
            occ_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            open_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= GRANT;
                        open_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    state_q    <= BUSY;
                    busy_cnt_q <= '0;
                end
                BUSY: begin
                    if (busy_cnt_q == BUSY_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            pending_q <= service ? 1'b0 : (pending_q || arrive_evt);

            if (grant && !exit_ok) begin
                occ_q <= occ_q + 1'b1;
            end else if (!grant && exit_ok) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    assign open_signal = open_q;
    assign busy        = busy_q;
    assign full        = full_w;
    assign free_spaces = CAP_V - occ_q;

`ifdef PARKING_DENY_LED_EN
    localparam int unsigned DW = $clog2(DENY_BLINK_CYC + 1);

    logic          deny;
    logic [DW-1:0] deny_cnt_q;
    logic          deny_led_q;

    assign deny = service && full_w;

    // Denial lights the LED immediately; the remaining count toggles it so
    // the pattern is on/off/on/off, and a new denial restarts it.
    always_ff @(posedge clk_2Hz or negedge reset) begin
        if (!reset) begin
            deny_cnt_q <= '0;
            deny_led_q <= 1'b0;
        end else if (deny) begin
            deny_cnt_q <= DW'(DENY_BLINK_CYC);
            deny_led_q <= 1'b1;
        end else if (deny_cnt_q > DW'(1)) begin
            deny_cnt_q <= deny_cnt_q - 1'b1;
            deny_led_q <= ~deny_led_q;
        end else begin
            deny_cnt_q <= '0;
            deny_led_q <= 1'b0;
        end
    end

    assign deny_led = deny_led_q;
`else
    assign deny_led = 1'b0;
`endif

endmodule

// File: doc/parking_entry_ctrl.md
Name: parking_entry_ctrl

Overview:
- Entry-side controller upstream of the door block.
- Debounces raw arrival/exit sensors, tracks lot occupancy against capacity, and issues a one-cycle open_signal pulse when a car may enter.
- Holds off further grants until the door blink sequence completes (busy lockout).
- Runs on the 2 Hz system tick.

Parameters:
- CAPACITY, 8: number of parking spaces.
- CNT_W, 4: occupancy/free-space width; must satisfy 2^CNT_W > CAPACITY.
- DEBOUNCE_CYC, 2: consecutive synchronised-high samples required to qualify a sensor event.
- DOOR_BUSY_CYC, 22: lockout cycles after a grant (1 latch + 20 blink + 1 clear).

Ports:
- clk_2Hz  input  1  2 Hz system clock
- reset  input  1  asynchronous, active-low reset
- car_arrive  input  1  raw entry sensor level; high = car at gate
- car_exit  input  1  raw exit sensor level; high = car leaving
- open_signal  output  1  one-cycle grant pulse to door stage
- free_spaces  output  CNT_W  CAPACITY minus occupancy
- full  output  1  high when occupancy == CAPACITY
- busy  output  1  high during grant/lockout
- deny_led  output  1  full-lot denial indicator (see Optional Feature)

Behaviour:
- Reset (async, reset==0) forces:
  - open_signal=0, busy=0, full=0, deny_led=0, free_spaces=CAPACITY.
  - State IDLE; all counters, sync flops and pending flag cleared.
- Reset mid-BUSY aborts to IDLE and discards occupancy.
- Sensor path, per sensor:
  - 2-flop synchroniser feeds debounce counter. Counter increments while synced level is high, saturates at DEBOUNCE_CYC, clears when low.
  - Event pulse: one cycle, at the edge where the count reaches DEBOUNCE_CYC.
  - Re-arms only after the synced level returns low: one event per sensor assertion.
- Latency: car_arrive held high from before edge n -> arrival event at edge n+3 -> open_signal high from edge n+4 to n+5 (IDLE, not full, DEBOUNCE_CYC=2).
- Pending flag:
  - Set by an arrival event in any state.
  - Cleared when serviced in IDLE (granted or denied).
- FSM states: IDLE, GRANT, BUSY.
  - IDLE: pending & !full -> GRANT. Pending & full -> clear pending, stay IDLE (deny).
  - GRANT, one cycle: open_signal=1, occupancy+1, busy=1 -> BUSY.
  - BUSY: busy=1, lockout counter runs DOOR_BUSY_CYC-1 cycles -> IDLE.
  - Next grant is possible no earlier than DOOR_BUSY_CYC+1 edges after the previous pulse.
- Occupancy rules:
  - Exit event decrements occupancy if >0; at 0 it is ignored.
  - Exit is serviced in every state, independent of the FSM.
  - Grant increment and exit decrement in the same cycle: net unchanged.
  - Grant never exceeds CAPACITY; full is re-evaluated in IDLE from the registered occupancy.
- Registered outputs:
  - full and free_spaces are combinational from the occupancy register, so they update the cycle after each change.
  - open_signal is registered; never high two consecutive cycles.
- An arrival during BUSY is queued and serviced on return to IDLE. Only one car can be queued; extra arrivals merge.

Optional Feature:
- Macro PARKING_DENY_LED_EN.
- Defined: each denial in IDLE toggles deny_led every cycle for 4 cycles, then drives it 0. A new denial during the blink restarts the 4-cycle count.
- Undefined: deny_led tied 0, no blink counter logic; denial still clears pending.

Decomposition:
- parking_pkg holds:
  - FSM state encoding (IDLE, GRANT, BUSY)
  - DOOR_BLINK_CYC=20 and derived DOOR_BUSY_CYC default
  - DEBOUNCE_CYC default
  - DENY_BLINK_CYC=4
- Sub-module sensor_debounce (synchroniser, debounce counter, re-arm one-shot), instantiated once for car_arrive and once for car_exit.

Test Plan:
- Reset, then car_arrive high 6 cycles -> open_signal single pulse at edge n+4, free_spaces 8->7, busy high for 22 cycles.
- Second arrival during BUSY -> no pulse until IDLE; pulse one edge after busy drops, free_spaces 7->6.
- Fill to CAPACITY=8, then arrival -> full=1, no open_signal; with PARKING_DENY_LED_EN deny_led toggles 4 cycles, without it stays 0.
- Glitch: car_arrive high 1 cycle then low -> no event, no pulse, occupancy unchanged.
- Exit event same edge as grant at occupancy 3 -> occupancy stays 3. Exit at occupancy 0 -> free_spaces stays 8.
- Assert reset mid-BUSY at occupancy 5 -> immediate open_signal=0, busy=0, free_spaces=8, state IDLE; held sensor must drop and re-assert before the next grant.
